// File: rtl/dsd_pkg.sv
// rtl/dsd_pkg.sv - shared types and constants for the adder/display datapath
package dsd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  localparam int BCD_DIGIT_W = 4;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7_n(input logic [3:0] digit, input logic blank);
    logic [6:0] seg;
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = SEG_BLANK;
      endcase
    end
    return seg;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_add3
  import dsd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= BCD_DIGIT_W'(5)) ? digit_i + BCD_DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to packed BCD converter with leading-zero flags
module bin2bcd_seq
  import dsd_pkg::*;
#(
  parameter int IN_W   = 5,
  parameter int DIGITS = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [IN_W-1:0]               bin_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
  output logic [DIGITS-1:0]             lz_o
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  conv_state_e         state_q, state_d;
  logic [IN_W-1:0]     shift_q, shift_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIGITS-1:0]   lz_q, lz_d;
  logic                out_valid_q, out_valid_d;
  logic [ACC_W-1:0]    adj;
  logic [ACC_W+IN_W-1:0] shifted;

  // lz[i] set when digit i and every digit above it are zero; the ones digit is never blanked
  function automatic logic [DIGITS-1:0] lz_of(input logic [ACC_W-1:0] acc);
    logic [DIGITS-1:0] lz;
    logic              all_zero;
    lz       = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (acc[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      lz[i]    = all_zero;
    end
    return lz;
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i(acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o(adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shifted = {adj, shift_q} << 1;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    lz_d        = lz_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          shift_d = bin_i;
          acc_d   = '0;
          cnt_d   = CNT_W'(IN_W);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d   = shifted[ACC_W+IN_W-1:IN_W];
        shift_d = shifted[IN_W-1:0];
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          lz_d    = lz_of(shifted[ACC_W+IN_W-1:IN_W]);
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      lz_q        <= lz_of('0);
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      lz_q        <= lz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = out_valid_q;
  assign bcd_o       = acc_q;
  assign lz_o        = lz_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq against a decimal arithmetic model
module tb_bin2bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] bcd;
  logic [1:0] lz;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = -1;

  bin2bcd_seq #(.IN_W(5), .DIGITS(2)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .bin_i      (bin),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .bcd_o      (bcd),
    .lz_o       (lz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] exp_bcd(input int v);
    logic [3:0] tens, ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  function automatic logic [1:0] exp_lz(input int v);
    return (v < 10) ? 2'b10 : 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full conversion of v; holds out_ready low for 'stall' cycles after the result appears.
  task automatic convert(input int v, input int stall, input bit chk_period);
    int n;
    bin       = 5'(v);
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    tick();
    if (chk_period && last_acc >= 0) chk("period", 32'(cyc - last_acc), 32'd7);
    last_acc = cyc;
    in_valid = 1'b0;
    bin      = 5'($urandom_range(0, 31));
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("latency", 32'(n), 32'd5);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk($sformatf("bcd_%0d", v), 32'(bcd), 32'(exp_bcd(v)));
    chk($sformatf("lz_%0d", v), 32'(lz), 32'(exp_lz(v)));
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_bcd", 32'(bcd), 32'(exp_bcd(v)));
      chk("hold_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("handshake_valid_drop", 32'(out_valid), 32'd0);
    chk("handshake_ready_rise", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bin = '0;

    // reset
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h00);
    chk("rst_lz", 32'(lz), 32'b10);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_bcd", 32'(bcd), 32'h00);
    chk("post_rst_lz", 32'(lz), 32'b10);

    // zero and boundaries
    convert(0, 0, 1'b0);
    convert(9, 0, 1'b0);
    convert(10, 0, 1'b0);
    convert(30, 0, 1'b0);
    convert(31, 0, 1'b0);

    // exhaustive back-to-back sweep
    last_acc = -1;
    for (int v = 0; v < 32; v++) convert(v, 0, 1'b1);

    // backpressure: result 5 held while 17 waits upstream
    convert(5, 0, 1'b0);
    bin = 5'd5; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("bp_latency", 32'(n), 32'd5);
    in_valid = 1'b1; bin = 5'd17;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("bp_bcd_hold", 32'(bcd), 32'h05);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_accept", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("bp17_latency", 32'(n), 32'd5);
    chk("bp17_bcd", 32'(bcd), 32'h17);
    chk("bp17_lz", 32'(lz), 32'b00);
    tick();

    // abort by reset after the third shift edge
    bin = 5'd25; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    seen = 0;
    repeat (3) begin tick(); if (out_valid) seen++; end
    rst_n = 1'b0;
    #1;
    chk("abort_rst_ready", 32'(in_ready), 32'd1);
    chk("abort_rst_valid", 32'(out_valid), 32'd0);
    chk("abort_rst_bcd", 32'(bcd), 32'h00);
    chk("abort_rst_lz", 32'(lz), 32'b10);
    repeat (2) begin tick(); if (out_valid) seen++; end
    rst_n = 1'b1;
    repeat (8) begin tick(); if (out_valid) seen++; end
    chk("abort_no_pulse", 32'(seen), 32'd0);
    convert(25, 0, 1'b0);

    // randomized values with random output stalls
    for (int r = 0; r < 24; r++) convert(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
